hazard_ctrl: RTL and testbench
==============================

HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have parameters, one per line: name, default, meaning:
- RA_W, 5, register address width.
- T_W, 2, Tuse/Tnew field width; value 3 in a Tuse field means the operand is unused.
- MULT_CYCLES, 5, mult/multu busy cycles after leaving E.
- DIV_CYCLES, 10, div/divu busy cycles after leaving E.
- CNT_W, 16, stall performance counter width.
REQ-002 SHALL have ports, one per line: name, direction, width, meaning:
- clk, in, 1, sole clock; all state updates on the rising edge.
- reset_n, in, 1, asynchronous active-low reset.
- rs_d, in, RA_W, rs address of the instruction in D.
- rt_d, in, RA_W, rt address of the instruction in D.
- tuse_rs_d, in, T_W, cycles until D uses rs.
- tuse_rt_d, in, T_W, cycles until D uses rt.
- md_use_d, in, 1, D is mult/div/mfhi/mflo/mthi/mtlo.
- wa_e, in, RA_W, destination register of the instruction in E (0 means no write).
- tnew_e, in, T_W, cycles until the E result is available.
- wa_m, in, RA_W, destination register of the instruction in M.
- tnew_m, in, T_W, cycles until the M result is available.
- md_start_e, in, 1, E holds mult/multu/div/divu this cycle.
- md_div_e, in, 1, qualifies md_start_e as div/divu.
- perf_clr, in, 1, synchronous clear of stall_cnt.
- pc_en, out, 1, PC write enable.
- d_reg_en, out, 1, IF/ID register enable.
- e_reg_flush, out, 1, ID/EX register flush (inserts a bubble).
- md_busy, out, 1, mult/div unit busy.
- stall_cnt, out, CNT_W, count of stalled cycles.

Function
REQ-003 SHALL compute a data stall as the OR of the following; rule a is evaluated for rs and rt independently:
- a: the source address is nonzero, equals wa_e, and tnew_e > its Tuse.
- b: the same test against wa_m and tnew_m.
REQ-004 A Tuse field equal to 3 SHALL never cause a data stall.
REQ-005 Register address 0 SHALL never cause a stall, whatever the Tuse or Tnew.
REQ-006 SHALL raise a md stall when md_use_d = 1 and either md_busy = 1 or md_start_e = 1.
REQ-007 stall SHALL be data stall OR md stall, purely combinational from the current inputs and md_busy, with zero-cycle latency.
REQ-008 SHALL drive pc_en = ~stall, d_reg_en = ~stall, e_reg_flush = stall.
REQ-009 SHALL hold a busy counter of width clog2(max(MULT_CYCLES, DIV_CYCLES) + 1).
REQ-010 md_busy SHALL equal (busy counter != 0), taken from a register with no combinational path from the inputs.
REQ-011 Busy counter next-state, in priority order:
- md_start_e = 1: load DIV_CYCLES if md_div_e = 1, else MULT_CYCLES.
- counter nonzero: decrement by 1.
- otherwise: hold 0.
REQ-012 md_start_e while already busy SHALL reload the counter; the new operation replaces the old one.
REQ-013 md_div_e SHALL be ignored when md_start_e = 0.
REQ-014 A mult started in E at edge k SHALL give md_busy = 1 for edges k+1 through k+MULT_CYCLES, and 0 from edge k+MULT_CYCLES+1.
REQ-015 stall_cnt next-state, in priority order:
- perf_clr = 1: 0.
- stall = 1 and stall_cnt != all-ones: +1.
- otherwise: hold; the counter saturates with no wrap.
REQ-016 perf_clr and stall in the same cycle SHALL result in 0.
REQ-017 When stall is 0, the block SHALL have no effect on the pipeline: pc_en = 1, d_reg_en = 1, e_reg_flush = 0.

Reset
REQ-018 While reset_n = 0, asynchronously and without waiting for a clock edge:
- busy counter = 0, so md_busy = 0.
- stall_cnt = 0.
REQ-019 The combinational outputs SHALL follow REQ-008 during reset; reset mid-division SHALL abort the busy countdown immediately.
REQ-020 Release of reset SHALL be sampled on the next rising clk edge, with no extra dead cycle.

Verification
REQ-021 Load-use:
- Stimulus: rs_d=8, tuse_rs_d=1, wa_e=8, tnew_e=2.
- Response: pc_en=0, d_reg_en=0, e_reg_flush=1.
- Next cycle, with wa_m=8, tnew_m=1: no stall.
REQ-022 $0 and unused operands:
- Stimulus: rs_d=0, wa_e=0, tnew_e=2, tuse=0.
- Response: no stall.
- Stimulus: rt_d=9, wa_e=9, tuse_rt_d=3, tnew_e=2.
- Response: no stall.
REQ-023 Mult then mflo:
- Stimulus: md_start_e=1, md_div_e=0 at edge 0; md_use_d=1 held.
- Response: stall during the start cycle and during edges 1..5; md_busy falls after edge 5; stall_cnt=6.
REQ-024 Div reload:
- Stimulus: div started; mult started 3 cycles later.
- Response: md_busy stays high exactly MULT_CYCLES cycles after the mult start edge.
REQ-025 Reset mid-operation:
- Stimulus: reset_n pulsed low between edges 4 cycles into a div.
- Response: md_busy=0 and stall_cnt=0 immediately, before the next edge.
REQ-026 Counter saturation:
- Stimulus: CNT_W=4, stall held 20 cycles.
- Response: stall_cnt=15 and holds.
- Stimulus: perf_clr=1 while stall=1.
- Response: stall_cnt=0 next edge.

Source files
------------

// File: rtl/hazard_ctrl.sv
// Pipeline hazard control: RAW data stalls, mult/div busy stalls, and a saturating stall counter.
// stall, pc_en, d_reg_en and e_reg_flush are combinational with zero latency; md_busy and stall_cnt are registered.
module hazard_ctrl #(
  parameter int RA_W        = 5,
  parameter int T_W         = 2,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [RA_W-1:0]  rs_d,
  input  logic [RA_W-1:0]  rt_d,
  input  logic [T_W-1:0]   tuse_rs_d,
  input  logic [T_W-1:0]   tuse_rt_d,
  input  logic             md_use_d,
  input  logic [RA_W-1:0]  wa_e,
  input  logic [T_W-1:0]   tnew_e,
  input  logic [RA_W-1:0]  wa_m,
  input  logic [T_W-1:0]   tnew_m,
  input  logic             md_start_e,
  input  logic             md_div_e,
  input  logic             perf_clr,
  output logic             pc_en,
  output logic             d_reg_en,
  output logic             e_reg_flush,
  output logic             md_busy,
  output logic [CNT_W-1:0] stall_cnt
);
  localparam int MD_MAX = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int BC_W   = $clog2(MD_MAX + 1);
  localparam logic [T_W-1:0] TUSE_NONE = T_W'(3);

  logic [BC_W-1:0]  r_busy_cnt;
  logic [CNT_W-1:0] r_stall_cnt;
  logic             w_hit_rs_e;
  logic             w_hit_rt_e;
  logic             w_hit_rs_m;
  logic             w_hit_rt_m;
  logic             w_data_stall;
  logic             w_md_stall;
  logic             w_stall;

  // A producer only blocks a consumer whose use comes before the result is ready.
  assign w_hit_rs_e = (rs_d != '0) && (rs_d == wa_e) && (tuse_rs_d != TUSE_NONE) && (tnew_e > tuse_rs_d);
  assign w_hit_rt_e = (rt_d != '0) && (rt_d == wa_e) && (tuse_rt_d != TUSE_NONE) && (tnew_e > tuse_rt_d);
  assign w_hit_rs_m = (rs_d != '0) && (rs_d == wa_m) && (tuse_rs_d != TUSE_NONE) && (tnew_m > tuse_rs_d);
  assign w_hit_rt_m = (rt_d != '0) && (rt_d == wa_m) && (tuse_rt_d != TUSE_NONE) && (tnew_m > tuse_rt_d);

  assign w_data_stall = w_hit_rs_e | w_hit_rt_e | w_hit_rs_m | w_hit_rt_m;
  assign w_md_stall   = md_use_d & (md_busy | md_start_e);
  assign w_stall      = w_data_stall | w_md_stall;

  assign pc_en       = ~w_stall;
  assign d_reg_en    = ~w_stall;
  assign e_reg_flush = w_stall;
  assign md_busy     = (r_busy_cnt != '0);
  assign stall_cnt   = r_stall_cnt;

  // A new start always reloads, so a mult issued over a running div replaces it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_busy_cnt <= '0;
    end else if (md_start_e) begin
      r_busy_cnt <= md_div_e ? BC_W'(DIV_CYCLES) : BC_W'(MULT_CYCLES);
    end else if (r_busy_cnt != '0) begin
      r_busy_cnt <= r_busy_cnt - BC_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_stall_cnt <= '0;
    end else if (perf_clr) begin
      r_stall_cnt <= '0;
    end else if (w_stall && (r_stall_cnt != '1)) begin
      r_stall_cnt <= r_stall_cnt + CNT_W'(1);
    end
  end
endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboarded bench for hazard_ctrl: reference model predicts each cycle's outputs, plus directed scenarios.
module tb_hazard_ctrl;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          reset_n;
  logic [4:0]    rs_d, rt_d, wa_e, wa_m;
  logic [1:0]    tuse_rs_d, tuse_rt_d, tnew_e, tnew_m;
  logic          md_use_d, md_start_e, md_div_e, perf_clr;
  logic          pc_en, d_reg_en, e_reg_flush, md_busy;
  logic [CW-1:0] stall_cnt;

  hazard_ctrl #(.CNT_W(CW)) dut (
    .clk(clk), .reset_n(reset_n),
    .rs_d(rs_d), .rt_d(rt_d), .tuse_rs_d(tuse_rs_d), .tuse_rt_d(tuse_rt_d),
    .md_use_d(md_use_d), .wa_e(wa_e), .tnew_e(tnew_e), .wa_m(wa_m), .tnew_m(tnew_m),
    .md_start_e(md_start_e), .md_div_e(md_div_e), .perf_clr(perf_clr),
    .pc_en(pc_en), .d_reg_en(d_reg_en), .e_reg_flush(e_reg_flush),
    .md_busy(md_busy), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          stall;
    logic          busy;
    logic [CW-1:0] cnt;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   m_busy   = 0;
  int   m_cnt    = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic src_hit(input logic [4:0] a, input logic [1:0] tu,
                                   input logic [4:0] wa, input logic [1:0] tn);
    return (a != 5'd0) && (a == wa) && (tu != 2'd3) && (tn > tu);
  endfunction

  function automatic logic model_stall();
    logic d;
    d = src_hit(rs_d, tuse_rs_d, wa_e, tnew_e) | src_hit(rt_d, tuse_rt_d, wa_e, tnew_e) |
        src_hit(rs_d, tuse_rs_d, wa_m, tnew_m) | src_hit(rt_d, tuse_rt_d, wa_m, tnew_m);
    return d | (md_use_d & ((m_busy != 0) | md_start_e));
  endfunction

  task automatic clear_inputs();
    rs_d = 0; rt_d = 0; wa_e = 0; wa_m = 0;
    tuse_rs_d = 0; tuse_rt_d = 0; tnew_e = 0; tnew_m = 0;
    md_use_d = 0; md_start_e = 0; md_div_e = 0; perf_clr = 0;
  endtask

  // Called at a negedge with inputs already driven; returns at the next negedge.
  task automatic cycle();
    exp_t e, o;
    e.stall = model_stall();
    e.busy  = (m_busy != 0);
    e.cnt   = CW'(m_cnt);
    sb.push_back(e);
    #1;
    o = sb.pop_front();
    chk("pc_en", pc_en, !o.stall);
    chk("d_reg_en", d_reg_en, !o.stall);
    chk("e_reg_flush", e_reg_flush, o.stall);
    chk("md_busy", md_busy, o.busy);
    chk("stall_cnt", stall_cnt, o.cnt);
    @(posedge clk);
    if (perf_clr) m_cnt = 0;
    else if (o.stall && m_cnt != (1 << CW) - 1) m_cnt++;
    if (md_start_e) m_busy = md_div_e ? 10 : 5;
    else if (m_busy > 0) m_busy--;
    @(negedge clk);
  endtask

  initial begin
    int n;
    clear_inputs();
    reset_n = 1'b0;
    #2;
    chk("rst_md_busy", md_busy, 0);
    chk("rst_stall_cnt", stall_cnt, 0);
    chk("rst_pc_en", pc_en, 1);
    @(negedge clk);
    reset_n = 1'b1;

    // Load-use from E, then resolved from M the next cycle
    rs_d = 8; tuse_rs_d = 1; wa_e = 8; tnew_e = 2;
    #1 chk("loaduse_flush", e_reg_flush, 1);
    chk("loaduse_pc_en", pc_en, 0);
    #1 cycle();
    wa_e = 0; tnew_e = 0; wa_m = 8; tnew_m = 1;
    #1 chk("loaduse_m_pc_en", pc_en, 1);
    #1 cycle();
    tnew_m = 2;
    cycle();
    clear_inputs(); rt_d = 5; wa_m = 5; tnew_m = 1; tuse_rt_d = 0;
    cycle();

    // $0 and unused operands; equal Tnew/Tuse does not stall
    clear_inputs(); rs_d = 0; wa_e = 0; tnew_e = 2;
    #1 chk("zero_reg_pc_en", pc_en, 1);
    #1 cycle();
    clear_inputs(); rt_d = 9; wa_e = 9; tuse_rt_d = 3; tnew_e = 2;
    #1 chk("unused_rt_pc_en", pc_en, 1);
    #1 cycle();
    clear_inputs(); rs_d = 4; wa_e = 4; tuse_rs_d = 2; tnew_e = 2;
    cycle();

    // Mult then mflo: stall in the start cycle plus MULT_CYCLES busy cycles
    clear_inputs(); perf_clr = 1;
    cycle();
    clear_inputs(); md_use_d = 1; md_start_e = 1; md_div_e = 0;
    cycle();
    md_start_e = 0;
    for (int i = 0; i < 7; i++) cycle();
    chk("mult_stall_cnt", stall_cnt, 6);
    chk("mult_busy_done", md_busy, 0);

    // Div reload by a later mult
    clear_inputs(); md_start_e = 1; md_div_e = 1;
    cycle();
    clear_inputs();
    cycle(); cycle();
    md_start_e = 1; md_div_e = 0;
    cycle();
    clear_inputs(); md_div_e = 1;
    n = 0;
    for (int i = 0; i < 10; i++) begin
      if (md_busy) n++;
      cycle();
    end
    chk("reload_busy_cycles", n, 5);

    // Reset mid-division aborts immediately
    clear_inputs(); md_use_d = 1; md_start_e = 1; md_div_e = 1;
    cycle();
    md_start_e = 0;
    for (int i = 0; i < 4; i++) cycle();
    chk("pre_rst_busy", md_busy, 1);
    md_use_d = 0;
    @(posedge clk);
    #2 md_use_d = 1; reset_n = 1'b0;
    #1 chk("midrst_md_busy", md_busy, 0);
    chk("midrst_stall_cnt", stall_cnt, 0);
    chk("midrst_pc_en", pc_en, 1);
    #1 reset_n = 1'b1;
    m_busy = 0; m_cnt = 0;
    @(negedge clk);
    cycle();

    // Saturation and clear-over-stall
    clear_inputs(); rs_d = 3; wa_e = 3; tuse_rs_d = 0; tnew_e = 1;
    for (int i = 0; i < 20; i++) cycle();
    chk("sat_stall_cnt", stall_cnt, 15);
    cycle();
    chk("sat_hold", stall_cnt, 15);
    perf_clr = 1;
    cycle();
    chk("clr_over_stall", stall_cnt, 0);

    // Random mix through the scoreboard
    for (int i = 0; i < 80; i++) begin
      rs_d = 5'($urandom_range(0, 3)); rt_d = 5'($urandom_range(0, 3));
      wa_e = 5'($urandom_range(0, 3)); wa_m = 5'($urandom_range(0, 3));
      tuse_rs_d = 2'($urandom_range(0, 3)); tuse_rt_d = 2'($urandom_range(0, 3));
      tnew_e = 2'($urandom_range(0, 3)); tnew_m = 2'($urandom_range(0, 3));
      md_use_d = 1'($urandom_range(0, 1));
      md_start_e = ($urandom_range(0, 7) == 0);
      md_div_e = 1'($urandom_range(0, 1));
      perf_clr = ($urandom_range(0, 15) == 0);
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
